mux_ctrl: RTL and testbench
===========================

// Module: mux_ctrl
// PURPOSE
//  PCIe-style byte-lane symbol multiplexer in the transmit path, ahead of the 8b/10b encoder.
//  A 4-bit select S chooses between the 8-bit payload byte and fixed K-code control symbols:
//  COM, PAD, SKP, STP, SDP, END, EDB, FTS, IDL and EIE.
//  outmux is registered, with an enable; outk flags bytes that are control (K) symbols.
// PARAMETERS
//  none -- data path fixed at 8 bits, select fixed at 4 bits, symbol codes fixed below
// PORTS
//  clk     in   1  single clock; all state updates on rising edge
//  reset   in   1  synchronous, active-high reset
//  data    in   8  payload byte (D-character)
//  enb     in   1  enable; 1 = update output per S, 0 = emit 0x00
//  S       in   4  symbol select (table below)
//  outmux  out  8  registered selected byte
//  outk    out  1  registered; 1 when outmux carries a K symbol
// BEHAVIOUR
//  - Clock and reset: one clock (clk); reset synchronous, active-high.
//    Reset sampled on rising edge: outmux=8'h00, outk=0. Reset has priority over enb and S.
//  - Select decode (S -> outmux, outk):
//      0000 data  , 0      0001 COM 8'hBC, 1   0010 PAD 8'hF7, 1
//      0011 SKP 8'h1C, 1   0100 STP 8'hFB, 1   0101 SDP 8'h5C, 1
//      0110 END 8'hFD, 1   0111 EDB 8'hFE, 1   1000 FTS 8'h3C, 1
//      1001 IDL 8'h7C, 1   1010 EIE 8'hFC, 1
//      1011..1111 reserved -> 8'h00, 0
//  - Latency: exactly 1 clk. Inputs (S, data, enb) are sampled at rising edge N.
//    The result is visible on outmux/outk after edge N; no combinational input->output path.
//  - enb=1 on an edge: load decoded value.
//    enb=0 on an edge: outmux=8'h00, outk=0, regardless of S/data.
//  - S=0000: data is passed verbatim, all 8 bits; data is ignored for every other S.
//  - Changing S every cycle is legal; each edge reflects only that edge's S.
//    No hold or hysteresis between symbols.
//  - Reset mid-stream: the next edge with reset=1 clears the outputs.
//    The first edge after reset deasserts uses normal decode.
//  - X/Z on S when enb=1: outputs undefined; no error flag is required.
// TESTING
//  1. reset=1 for 2 edges, S=0001, enb=1 -> outmux=00, outk=0; release -> next edge outmux=BC, outk=1
//  2. enb=1, data=8'h0A, S=0000 -> after 1 edge outmux=0A, outk=0; data=8'hA5 -> next edge A5
//  3. sweep S=0010,0100,0101,0110,1001,0011 one per edge -> F7,FB,5C,FD,7C,1C each one edge late, outk=1
//  4. S=0111,1000,1010 -> FE,3C,FC; S=1011..1111 -> 00 with outk=0
//  5. S=0100 with enb toggled 1,0,1 -> FB,00,FB; reset=1 while enb=1, S=0110 -> 00 at that edge
//  6. Apply S change between edges -> outmux must not change until next rising clk edge

Source files
------------

// File: rtl/mux_ctrl.sv
// Transmit-path byte-lane symbol multiplexer ahead of the 8b/10b encoder.
// Picks the payload byte or a fixed K-code per S and registers the result with a K flag.
module mux_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       enb,
    input  logic [3:0] S,
    output logic [7:0] outmux,
    output logic       outk
);

    localparam logic [3:0] SEL_DATA = 4'b0000;
    localparam logic [3:0] SEL_COM  = 4'b0001;
    localparam logic [3:0] SEL_PAD  = 4'b0010;
    localparam logic [3:0] SEL_SKP  = 4'b0011;
    localparam logic [3:0] SEL_STP  = 4'b0100;
    localparam logic [3:0] SEL_SDP  = 4'b0101;
    localparam logic [3:0] SEL_END  = 4'b0110;
    localparam logic [3:0] SEL_EDB  = 4'b0111;
    localparam logic [3:0] SEL_FTS  = 4'b1000;
    localparam logic [3:0] SEL_IDL  = 4'b1001;
    localparam logic [3:0] SEL_EIE  = 4'b1010;

    localparam logic [7:0] K_COM = 8'hBC;
    localparam logic [7:0] K_PAD = 8'hF7;
    localparam logic [7:0] K_SKP = 8'h1C;
    localparam logic [7:0] K_STP = 8'hFB;
    localparam logic [7:0] K_SDP = 8'h5C;
    localparam logic [7:0] K_END = 8'hFD;
    localparam logic [7:0] K_EDB = 8'hFE;
    localparam logic [7:0] K_FTS = 8'h3C;
    localparam logic [7:0] K_IDL = 8'h7C;
    localparam logic [7:0] K_EIE = 8'hFC;

    logic [7:0] sym_sel;
    logic       k_sel;
    logic [7:0] outmux_d, outmux_q;
    logic       outk_d, outk_q;

    always_comb begin
        sym_sel = 8'h00;
        k_sel   = 1'b0;
        case (S)
            SEL_DATA: begin sym_sel = data;  k_sel = 1'b0; end
            SEL_COM:  begin sym_sel = K_COM; k_sel = 1'b1; end
            SEL_PAD:  begin sym_sel = K_PAD; k_sel = 1'b1; end
            SEL_SKP:  begin sym_sel = K_SKP; k_sel = 1'b1; end
            SEL_STP:  begin sym_sel = K_STP; k_sel = 1'b1; end
            SEL_SDP:  begin sym_sel = K_SDP; k_sel = 1'b1; end
            SEL_END:  begin sym_sel = K_END; k_sel = 1'b1; end
            SEL_EDB:  begin sym_sel = K_EDB; k_sel = 1'b1; end
            SEL_FTS:  begin sym_sel = K_FTS; k_sel = 1'b1; end
            SEL_IDL:  begin sym_sel = K_IDL; k_sel = 1'b1; end
            SEL_EIE:  begin sym_sel = K_EIE; k_sel = 1'b1; end
            default:  begin sym_sel = 8'h00; k_sel = 1'b0; end
        endcase
    end

    // A disabled lane emits a plain zero byte rather than holding the last symbol.
    always_comb begin
        outmux_d = 8'h00;
        outk_d   = 1'b0;
        if (enb) begin
            outmux_d = sym_sel;
            outk_d   = k_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            outmux_q <= 8'h00;
            outk_q   <= 1'b0;
        end else begin
            outmux_q <= outmux_d;
            outk_q   <= outk_d;
        end
    end

    assign outmux = outmux_q;
    assign outk   = outk_q;

endmodule

// File: tb/tb_mux_ctrl.sv
// Directed bench for mux_ctrl: hand-computed symbol/K expectations per scenario.
module tb_mux_ctrl;

    logic       clk;
    logic       reset;
    logic [7:0] data;
    logic       enb;
    logic [3:0] S;
    logic [7:0] outmux;
    logic       outk;

    int checks;
    int failures;

    mux_ctrl dut (
        .clk    (clk),
        .reset  (reset),
        .data   (data),
        .enb    (enb),
        .S      (S),
        .outmux (outmux),
        .outk   (outk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it before sampling.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; enb = 1'b1; S = 4'b0001; data = 8'h55;
        tick();
        tick();
        checks++;
        if (outmux !== 8'h00) begin
            failures++;
            $display("FAIL reset_outmux got=%h exp=00", outmux);
        end
        checks++;
        if (outk !== 1'b0) begin
            failures++;
            $display("FAIL reset_outk got=%b exp=0", outk);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (outmux !== 8'hBC || outk !== 1'b1) begin
            failures++;
            $display("FAIL release_com got=%h/%b exp=bc/1", outmux, outk);
        end
    endtask

    task automatic test_data_pass;
        logic [7:0] dv [3];
        dv = '{8'h0A, 8'hA5, 8'hFF};
        S = 4'b0000; enb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data = dv[i];
            tick();
            checks++;
            if (outmux !== dv[i] || outk !== 1'b0) begin
                failures++;
                $display("FAIL data_pass[%0d] got=%h/%b exp=%h/0", i, outmux, outk, dv[i]);
            end
        end
    endtask

    task automatic test_sweep;
        logic [3:0] sv [6];
        logic [7:0] ev [6];
        sv = '{4'b0010, 4'b0100, 4'b0101, 4'b0110, 4'b1001, 4'b0011};
        ev = '{8'hF7, 8'hFB, 8'h5C, 8'hFD, 8'h7C, 8'h1C};
        enb = 1'b1; data = 8'h33;
        for (int i = 0; i < 6; i++) begin
            S = sv[i];
            tick();
            checks++;
            if (outmux !== ev[i] || outk !== 1'b1) begin
                failures++;
                $display("FAIL sweep[%0d] S=%b got=%h/%b exp=%h/1", i, sv[i], outmux, outk, ev[i]);
            end
        end
    endtask

    task automatic test_remaining_and_reserved;
        logic [3:0] sv [3];
        logic [7:0] ev [3];
        sv = '{4'b0111, 4'b1000, 4'b1010};
        ev = '{8'hFE, 8'h3C, 8'hFC};
        enb = 1'b1; data = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            S = sv[i];
            tick();
            checks++;
            if (outmux !== ev[i] || outk !== 1'b1) begin
                failures++;
                $display("FAIL ksym[%0d] S=%b got=%h/%b exp=%h/1", i, sv[i], outmux, outk, ev[i]);
            end
        end
        for (int r = 11; r <= 15; r++) begin
            S = 4'b0001;
            tick();
            S = r[3:0];
            tick();
            checks++;
            if (outmux !== 8'h00 || outk !== 1'b0) begin
                failures++;
                $display("FAIL reserved S=%b got=%h/%b exp=00/0", r[3:0], outmux, outk);
            end
        end
    endtask

    task automatic test_enable;
        logic       en_v [3];
        logic [7:0] ev [3];
        en_v = '{1'b1, 1'b0, 1'b1};
        ev   = '{8'hFB, 8'h00, 8'hFB};
        S = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            enb = en_v[i];
            tick();
            checks++;
            if (outmux !== ev[i] || outk !== en_v[i]) begin
                failures++;
                $display("FAIL enable[%0d] got=%h/%b exp=%h/%b", i, outmux, outk, ev[i], en_v[i]);
            end
        end
        S = 4'b0000; data = 8'hC3; enb = 1'b0;
        tick();
        checks++;
        if (outmux !== 8'h00 || outk !== 1'b0) begin
            failures++;
            $display("FAIL enable_off_data got=%h/%b exp=00/0", outmux, outk);
        end
        enb = 1'b1;
    endtask

    task automatic test_reset_mid;
        enb = 1'b1; S = 4'b0110;
        tick();
        checks++;
        if (outmux !== 8'hFD || outk !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset got=%h/%b exp=fd/1", outmux, outk);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (outmux !== 8'h00 || outk !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got=%h/%b exp=00/0", outmux, outk);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (outmux !== 8'hFD || outk !== 1'b1) begin
            failures++;
            $display("FAIL post_reset got=%h/%b exp=fd/1", outmux, outk);
        end
    endtask

    task automatic test_between_edges;
        enb = 1'b1; S = 4'b0001;
        tick();
        #2;
        S = 4'b0000; data = 8'h69;
        #1;
        checks++;
        if (outmux !== 8'hBC || outk !== 1'b1) begin
            failures++;
            $display("FAIL hold_sel got=%h/%b exp=bc/1", outmux, outk);
        end
        enb = 1'b0;
        #1;
        checks++;
        if (outmux !== 8'hBC || outk !== 1'b1) begin
            failures++;
            $display("FAIL hold_enb got=%h/%b exp=bc/1", outmux, outk);
        end
        enb = 1'b1; S = 4'b0010;
        tick();
        checks++;
        if (outmux !== 8'hF7 || outk !== 1'b1) begin
            failures++;
            $display("FAIL after_edge got=%h/%b exp=f7/1", outmux, outk);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] sv [5];
        logic [7:0] ev [5];
        logic       kv [5];
        sv = '{4'b0000, 4'b0001, 4'b0000, 4'b1111, 4'b1010};
        ev = '{8'h5A, 8'hBC, 8'h5A, 8'h00, 8'hFC};
        kv = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        enb = 1'b1; data = 8'h5A;
        for (int i = 0; i < 5; i++) begin
            S = sv[i];
            tick();
            checks++;
            if (outmux !== ev[i] || outk !== kv[i]) begin
                failures++;
                $display("FAIL b2b[%0d] got=%h/%b exp=%h/%b", i, outmux, outk, ev[i], kv[i]);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1; enb = 1'b0; S = 4'b0000; data = 8'h00;
        test_reset();
        test_data_pass();
        test_sweep();
        test_remaining_and_reserved();
        test_enable();
        test_reset_mid();
        test_between_edges();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
